// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline-controller state encoding.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pcstate_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_MemRead,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     hazard_c
);

  // $zero never carries a real dependency
  assign hazard_c = ex_MemRead && (ex_wsel != '0) &&
                    ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/sequencing unit: cache-wait stalls, load-use bubbles,
// wrong-path squash and halt freeze for the five-stage pipeline.
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_MemRead,
  input  regbits_t         ex_wsel,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_jump,
  input  logic             wb_halt,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             pc_en,
  output logic             fl_en,
  output logic             fl_flush,
  output logic             dl_en,
  output logic             dl_flush,
  output logic             el_en,
  output logic             el_flush,
  output logic             ml_en,
  output logic             ml_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  pcstate_t state, next_state;
  logic     ihit_seen, dhit_seen;
  logic     dmem_req_c, ifetch_done_c, dmem_done_c, advance_c, hazard_c;

  load_use_detect u_load_use_detect (
    .ex_MemRead (ex_MemRead),
    .ex_wsel    (ex_wsel),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hazard_c   (hazard_c)
  );

  assign dmem_req_c    = mem_dREN | mem_dWEN;
  assign ifetch_done_c = ihit | ihit_seen;
  assign dmem_done_c   = ~dmem_req_c | dhit | dhit_seen;
  assign halt          = (state == HALTED);

  // State, completion flags and stall counter
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= INIT;
      ihit_seen <= 1'b0;
      dhit_seen <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (advance_c) begin
        ihit_seen <= 1'b0;
        dhit_seen <= 1'b0;
      end else if (state == RUN) begin
        if (ihit)              ihit_seen <= 1'b1;
        if (dhit && dmem_req_c) dhit_seen <= 1'b1;
      end
      if ((state == RUN) && !advance_c && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Next state and Mealy control outputs
  always_comb begin
    next_state = state;
    advance_c  = 1'b0;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    pc_en      = 1'b0;
    fl_en      = 1'b0;
    fl_flush   = 1'b0;
    dl_en      = 1'b0;
    dl_flush   = 1'b0;
    el_en      = 1'b0;
    el_flush   = 1'b0;
    ml_en      = 1'b0;
    ml_flush   = 1'b0;

    case (state)
      INIT: begin
        fl_flush   = 1'b1;
        dl_flush   = 1'b1;
        el_flush   = 1'b1;
        ml_flush   = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        iREN = ~ihit_seen;
        dREN = mem_dREN & ~dhit_seen;
        dWEN = mem_dWEN & ~dhit_seen;
        if (wb_halt) begin
          next_state = HALTED;
        end else if (ifetch_done_c && dmem_done_c) begin
          advance_c = 1'b1;
          if (mem_branch_taken || mem_jump) begin
            pc_en    = 1'b1;
            fl_flush = 1'b1;
            dl_flush = 1'b1;
            el_flush = 1'b1;
            ml_en    = 1'b1;
          end else if (hazard_c) begin
            dl_flush = 1'b1;
            el_en    = 1'b1;
            ml_en    = 1'b1;
          end else begin
            pc_en = 1'b1;
            fl_en = 1'b1;
            dl_en = 1'b1;
            el_en = 1'b1;
            ml_en = 1'b1;
          end
        end
      end
      HALTED: next_state = HALTED;
      default: next_state = INIT;
    endcase
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller.
module tb_pipeline_controller;
  import cpu_types_pkg::*;

  logic        CLK, nRST;
  logic        ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead;
  regbits_t    ex_wsel, id_rs, id_rt;
  logic        mem_branch_taken, mem_jump, wb_halt;
  logic        iREN, dREN, dWEN, pc_en;
  logic        fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush, ml_en, ml_flush;
  logic        halt;
  logic [31:0] stall_cnt;

  int n_pass = 0;
  int n_total = 0;

  pipeline_controller #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_MemRead(ex_MemRead),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump), .wb_halt(wb_halt),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .pc_en(pc_en),
    .fl_en(fl_en), .fl_flush(fl_flush), .dl_en(dl_en), .dl_flush(dl_flush),
    .el_en(el_en), .el_flush(el_flush), .ml_en(ml_en), .ml_flush(ml_flush),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {pc_en, fl_en, dl_en, el_en, ml_en}
  function automatic logic [4:0] ens();
    return {pc_en, fl_en, dl_en, el_en, ml_en};
  endfunction

  // {fl, dl, el, ml} flushes
  function automatic logic [3:0] fls();
    return {fl_flush, dl_flush, el_flush, ml_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    ihit = 0; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_MemRead = 0;
    ex_wsel = '0; id_rs = '0; id_rt = '0;
    mem_branch_taken = 0; mem_jump = 0; wb_halt = 0;
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    settle();
    // INIT cycle
    chk("init_flush", 32'(fls()), 32'hF);
    chk("init_en", 32'(ens()), 32'h0);
    chk("init_iren", 32'(iREN), 32'h0);
    chk("init_halt", 32'(halt), 32'h0);
    chk("init_cnt", stall_cnt, 32'd0);

    // ihit arrives first, dhit three cycles later
    tick(); ihit = 1; mem_dREN = 1; settle();
    chk("r0_iren", 32'(iREN), 32'h1);
    chk("r0_dren", 32'(dREN), 32'h1);
    chk("r0_cnt", stall_cnt, 32'd0);
    chk("r0_en", 32'(ens()), 32'h0);
    tick(); ihit = 0; settle();
    chk("r1_iren", 32'(iREN), 32'h0);
    chk("r1_en", 32'(ens()), 32'h0);
    chk("r1_cnt", stall_cnt, 32'd1);
    tick(); settle();
    chk("r2_iren", 32'(iREN), 32'h0);
    tick(); dhit = 1; settle();
    chk("r3_iren", 32'(iREN), 32'h0);
    chk("r3_en", 32'(ens()), 32'h1F);
    chk("r3_flush", 32'(fls()), 32'h0);
    chk("r3_cnt", stall_cnt, 32'd3);

    // dhit first, ihit later
    tick(); dhit = 1; ihit = 0; settle();
    chk("r4_iren", 32'(iREN), 32'h1);
    chk("r4_dren", 32'(dREN), 32'h1);
    chk("r4_cnt", stall_cnt, 32'd3);
    tick(); dhit = 0; settle();
    chk("r5_dren", 32'(dREN), 32'h0);
    chk("r5_en", 32'(ens()), 32'h0);
    tick(); ihit = 1; settle();
    chk("r6_en", 32'(ens()), 32'h1F);
    chk("r6_cnt", stall_cnt, 32'd5);

    // dhit with no MEM request must not be remembered
    tick(); ihit = 0; dhit = 1; mem_dREN = 0; settle();
    chk("r7_en", 32'(ens()), 32'h0);
    tick(); ihit = 1; dhit = 0; mem_dREN = 1; settle();
    chk("r8_dren", 32'(dREN), 32'h1);
    chk("r8_en", 32'(ens()), 32'h0);
    tick(); ihit = 0; dhit = 1; settle();
    chk("r9_en", 32'(ens()), 32'h1F);

    // load-use on rt
    tick(); ihit = 1; dhit = 0; mem_dREN = 0;
    ex_MemRead = 1; ex_wsel = 5'd8; id_rt = 5'd8; id_rs = 5'd3; settle();
    chk("lu_pc_fl", 32'({pc_en, fl_en}), 32'h0);
    chk("lu_dl_flush", 32'(dl_flush), 32'h1);
    chk("lu_el_ml", 32'({el_en, ml_en}), 32'h3);
    // destination $zero: no bubble
    ex_wsel = 5'd0; id_rt = 5'd0; settle();
    chk("lu_zero_en", 32'(ens()), 32'h1F);
    chk("lu_zero_flush", 32'(fls()), 32'h0);
    // load-use on rs
    ex_wsel = 5'd17; id_rs = 5'd17; id_rt = 5'd2; settle();
    chk("lu_rs_pc", 32'(pc_en), 32'h0);
    ex_MemRead = 0; settle();
    chk("nolu_en", 32'(ens()), 32'h1F);

    // branch beats load-use
    ex_MemRead = 1; ex_wsel = 5'd8; id_rt = 5'd8; mem_branch_taken = 1; settle();
    chk("br_pc", 32'(pc_en), 32'h1);
    chk("br_flush", 32'(fls()), 32'hE);
    chk("br_en", 32'(ens()), 32'h11);
    mem_branch_taken = 0; mem_jump = 1; ex_MemRead = 0; settle();
    chk("jmp_flush", 32'(fls()), 32'hE);

    // reset mid-stall discards flags
    tick(); clear_inputs(); ihit = 1; mem_dREN = 1; settle();
    chk("ms_en", 32'(ens()), 32'h0);
    tick(); ihit = 0; nRST = 0; settle();
    chk("ms_iren", 32'(iREN), 32'h0);
    tick(); nRST = 1; settle();
    chk("ms_init_flush", 32'(fls()), 32'hF);
    chk("ms_init_cnt", stall_cnt, 32'd0);
    tick(); settle();
    chk("ms_run_req", 32'({iREN, dREN}), 32'h3);

    // halt with a pending branch
    ihit = 1; mem_dREN = 0; mem_branch_taken = 1; wb_halt = 1; settle();
    chk("h0_en", 32'(ens()), 32'h0);
    chk("h0_flush", 32'(fls()), 32'h0);
    chk("h0_halt", 32'(halt), 32'h0);
    tick(); wb_halt = 0;
    for (int i = 0; i < 100; i++) begin
      settle();
      chk("h_halt", 32'(halt), 32'h1);
      chk("h_outs", 32'({iREN, dREN, dWEN, ens(), fls()}), 32'h0);
      tick();
    end
    nRST = 0;
    tick(); nRST = 1; clear_inputs(); settle();
    chk("hr_halt", 32'(halt), 32'h0);
    chk("hr_flush", 32'(fls()), 32'hF);
    chk("hr_cnt", stall_cnt, 32'd0);
    tick(); settle();
    chk("hr_run_iren", 32'(iREN), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
